// File: rtl/sample_capture_if.sv
// Sampling port between the FPGA requester and the QLA-side capture block,
// plus the board register read bus that the capture block borrows while busy.
interface sample_capture_if;
  logic        sample_start;
  logic [3:0]  sample_chan;
  logic [31:0] timestamp;
  logic        sample_busy;
  logic [15:0] reg_raddr;
  logic [31:0] reg_rdata;
  logic [5:0]  sample_raddr;
  logic [31:0] sample_rdata;
  logic        sample_done;

  modport slave (
    input  sample_start, sample_chan, timestamp, reg_rdata, sample_raddr,
    output sample_busy, reg_raddr, sample_rdata, sample_done
  );

  modport master (
    output sample_start, sample_chan, timestamp, reg_rdata, sample_raddr,
    input  sample_busy, reg_raddr, sample_rdata, sample_done
  );
endinterface

// File: rtl/sample_capture.sv
// Block-read sample responder: walks a fixed register address list into a sample buffer.
// Optional SAMPLE_CAPTURE_DBLBUF_EN: double-buffered banks so reads always see the last full frame.
module sample_capture #(
  parameter int NUM_MOTORS   = 4,
  parameter int NUM_ENCODERS = 4
) (
  input  logic            sysclk,
  input  logic            reset,
  sample_capture_if.slave bus
);
  localparam int         NUM_QUADS  = 4 + 2 * NUM_MOTORS + 5 * NUM_ENCODERS;
  localparam logic [5:0] LAST_IDX   = 6'(NUM_QUADS - 1);
  localparam logic [6:0] QUAD_LIMIT = 7'(NUM_QUADS);
  localparam logic [5:0] ADC_BASE   = 6'd4;
  localparam logic [5:0] MST_BASE   = 6'(4 + NUM_MOTORS);
  localparam logic [5:0] ENC_BASE   = 6'(4 + 2 * NUM_MOTORS);
  localparam logic [5:0] ENC_N      = 6'(NUM_ENCODERS);

  if (NUM_MOTORS < 1 || NUM_MOTORS > 8) begin : g_bad_motors
    $error("sample_capture: NUM_MOTORS must be in 1..8");
  end
  if (NUM_ENCODERS < 1 || NUM_ENCODERS > 8) begin : g_bad_encoders
    $error("sample_capture: NUM_ENCODERS must be in 1..8");
  end
  if (NUM_QUADS > 64) begin : g_bad_quads
    $error("sample_capture: frame does not fit the 64-entry buffer");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Encoder entries are grouped by register type, channel is the inner loop.
  function automatic logic [15:0] quad_addr(input logic [5:0] idx);
    logic [15:0] a;
    logic [5:0]  k;
    k = idx - ENC_BASE;
    if (idx == 6'd2) begin
      a = 16'h000A;
    end else if (idx == 6'd3) begin
      a = 16'h000B;
    end else if (idx >= ADC_BASE && idx < MST_BASE) begin
      a = {8'h00, 4'(idx - 6'd3), 4'h0};
    end else if (idx >= MST_BASE && idx < ENC_BASE) begin
      a = {8'h00, 4'(idx - MST_BASE + 6'd1), 4'hC};
    end else if (idx >= ENC_BASE) begin
      a = {8'h00, 4'(k % ENC_N + 6'd1), 4'h2 + 4'(k / ENC_N)};
    end else begin
      a = 16'h0000;
    end
    return a;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [5:0]  index_r, index_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;
  logic [15:0] raddr_r, raddr_nxt_s;
  logic        cap_valid_r;
  logic [5:0]  cap_idx_r;
  logic [31:0] rdata_r;
  logic        wr_en_s;
  logic [5:0]  wr_addr_s;
  logic [31:0] wr_data_s;
  logic        rd_in_range_s;

  assign bus.sample_busy  = busy_r;
  assign bus.sample_done  = done_r;
  assign bus.reg_raddr    = raddr_r;
  assign bus.sample_rdata = rdata_r;
  assign rd_in_range_s    = ({1'b0, bus.sample_raddr} < QUAD_LIMIT);

  // State, index and registered outputs; read data trails the address by one cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_r     <= IDLE;
      index_r     <= 6'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      raddr_r     <= 16'h0000;
      cap_valid_r <= 1'b0;
      cap_idx_r   <= 6'd0;
    end else begin
      state_r     <= state_nxt_s;
      index_r     <= index_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      raddr_r     <= raddr_nxt_s;
      cap_valid_r <= (state_r == RUN);
      cap_idx_r   <= index_r;
    end
  end

  // Next state; starts outside IDLE are dropped, not queued.
  always_comb begin
    state_nxt_s = state_r;
    index_nxt_s = index_r;
    case (state_r)
      IDLE: begin
        if (bus.sample_start) begin
          state_nxt_s = RUN;
          index_nxt_s = 6'd1;
        end else begin
          state_nxt_s = IDLE;
          index_nxt_s = 6'd0;
        end
      end
      RUN: begin
        if (index_r == LAST_IDX) begin
          state_nxt_s = FLUSH;
          index_nxt_s = 6'd0;
        end else begin
          state_nxt_s = RUN;
          index_nxt_s = index_r + 6'd1;
        end
      end
      FLUSH: begin
        state_nxt_s = DONE;
        index_nxt_s = 6'd0;
      end
      DONE: begin
        state_nxt_s = IDLE;
        index_nxt_s = 6'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        index_nxt_s = 6'd0;
      end
    endcase
  end

  // Output values for the coming cycle.
  always_comb begin
    busy_nxt_s = (state_nxt_s == RUN) || (state_nxt_s == FLUSH);
    done_nxt_s = (state_nxt_s == DONE);
    if (state_nxt_s == RUN) begin
      raddr_nxt_s = quad_addr(index_nxt_s);
    end else begin
      raddr_nxt_s = 16'h0000;
    end
  end

  // Header quadlet at start, then register data one cycle behind its address.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 6'd0;
    wr_data_s = 32'h0000_0000;
    if (reset) begin
      wr_en_s = 1'b0;
    end else if (state_r == IDLE && bus.sample_start) begin
      wr_en_s   = 1'b1;
      wr_addr_s = 6'd0;
      wr_data_s = {bus.sample_chan, bus.timestamp[27:0]};
    end else if (cap_valid_r) begin
      wr_en_s   = 1'b1;
      wr_addr_s = cap_idx_r;
      wr_data_s = bus.reg_rdata;
    end else begin
      wr_en_s = 1'b0;
    end
  end

`ifdef SAMPLE_CAPTURE_DBLBUF_EN
  logic [31:0] bank_r [0:1][0:63];
  logic        front_r;
  logic        bank_valid_r;

  // Capture always lands in the back bank.
  always_ff @(posedge sysclk) begin
    if (wr_en_s) begin
      bank_r[~front_r][wr_addr_s] <= wr_data_s;
    end
  end

  // Swap on frame completion, together with sample_done.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      front_r      <= 1'b0;
      bank_valid_r <= 1'b0;
    end else if (state_nxt_s == DONE) begin
      front_r      <= ~front_r;
      bank_valid_r <= 1'b1;
    end
  end

  // Read port serves the front bank only.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rdata_r <= 32'h0000_0000;
    end else if (bank_valid_r && rd_in_range_s) begin
      rdata_r <= bank_r[front_r][bus.sample_raddr];
    end else begin
      rdata_r <= 32'h0000_0000;
    end
  end
`else
  logic [31:0] buf_r [0:63];

  // Single bank: contents are only coherent after sample_done.
  always_ff @(posedge sysclk) begin
    if (wr_en_s) begin
      buf_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Registered read; same-cycle write to the same entry returns the old word.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rdata_r <= 32'h0000_0000;
    end else if (rd_in_range_s) begin
      rdata_r <= buf_r[bus.sample_raddr];
    end else begin
      rdata_r <= 32'h0000_0000;
    end
  end
`endif
endmodule

// File: tb/tb_sample_capture.sv
// Directed/randomized bench for sample_capture; expected frames come from an address
// list built from the board register map and a simple register-file responder.
module tb_sample_capture;
  localparam int M = 4;
  localparam int E = 4;
  localparam int N = 4 + 2 * M + 5 * E;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sample_capture_if bus_if ();

  sample_capture #(.NUM_MOTORS(M), .NUM_ENCODERS(E)) dut (
    .sysclk(clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] addr_list [0:63];
  logic [31:0] exp_buf   [0:63];
  bit          have_frame = 1'b0;
  logic [15:0] rd_tag = 16'h0000;

  // Register file: returns {tag, address} one cycle after the address is presented.
  always @(posedge clk) bus_if.reg_rdata <= {rd_tag, bus_if.reg_raddr};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_addr_list();
    int n;
    addr_list[0] = 16'h0000;
    addr_list[1] = 16'h0000;
    addr_list[2] = 16'h000A;
    addr_list[3] = 16'h000B;
    n = 4;
    for (int c = 1; c <= M; c++) begin addr_list[n] = 16'(c * 16);      n++; end
    for (int c = 1; c <= M; c++) begin addr_list[n] = 16'(c * 16 + 12); n++; end
    for (int off = 2; off <= 6; off++)
      for (int c = 1; c <= E; c++) begin addr_list[n] = 16'(c * 16 + off); n++; end
    for (int j = n; j < 64; j++) addr_list[j] = 16'h0000;
  endtask

  // One frame from cycle T; extra start pulses at T+inj_a / T+inj_b.
  task automatic run_frame(input logic [31:0] ts, input logic [3:0] chan,
                           input logic [15:0] tag, input int inj_a, input int inj_b);
    tick();
    chk("idle_before_start", {31'd0, bus_if.sample_busy}, 32'd0);
    rd_tag = tag;
    bus_if.sample_start = 1'b1;
    bus_if.sample_chan  = chan;
    bus_if.timestamp    = ts;
    for (int k = 1; k <= N + 1; k++) begin
      tick();
      bus_if.sample_start = (k == inj_a) || (k == inj_b);
      bus_if.sample_chan  = 4'($urandom);
      bus_if.timestamp    = $urandom;
      chk($sformatf("busy_t%0d", k), {31'd0, bus_if.sample_busy}, 32'(k <= N));
      chk($sformatf("done_t%0d", k), {31'd0, bus_if.sample_done}, 32'(k == N + 1));
      if (k < N) chk($sformatf("raddr_t%0d", k), {16'd0, bus_if.reg_raddr}, {16'd0, addr_list[k]});
      else if (k == N + 1) chk("raddr_idle", {16'd0, bus_if.reg_raddr}, 32'd0);
`ifdef SAMPLE_CAPTURE_DBLBUF_EN
      if (k == 8) bus_if.sample_raddr = 6'd5;
      if (k == 9) chk("mid_frame_read", bus_if.sample_rdata, have_frame ? exp_buf[5] : 32'd0);
`endif
    end
    exp_buf[0] = {chan, ts[27:0]};
    for (int i = 1; i < N; i++) exp_buf[i] = {tag, addr_list[i]};
    have_frame = 1'b1;
  endtask

  task automatic read_check(input logic [5:0] a, input string tag);
    bus_if.sample_raddr = a;
    tick();
    chk(tag, bus_if.sample_rdata, (int'(a) < N && have_frame) ? exp_buf[a] : 32'd0);
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) read_check(6'(a), $sformatf("buf%0d", a));
    read_check(6'd31, "read_q31");
    read_check(6'd40, "read_oob40");
    read_check(6'd63, "read_oob63");
  endtask

  initial begin
    int done_seen;
    reset = 1'b1;
    bus_if.sample_start = 1'b0;
    bus_if.sample_chan  = 4'h0;
    bus_if.timestamp    = 32'h0000_0000;
    bus_if.sample_raddr = 6'd0;
    build_addr_list();
    tick(); tick(); tick();
    chk("rst_busy",  {31'd0, bus_if.sample_busy}, 32'd0);
    chk("rst_done",  {31'd0, bus_if.sample_done}, 32'd0);
    chk("rst_raddr", {16'd0, bus_if.reg_raddr}, 32'd0);
    chk("rst_rdata", bus_if.sample_rdata, 32'd0);
    reset = 1'b0;
`ifdef SAMPLE_CAPTURE_DBLBUF_EN
    read_check(6'd3, "pre_frame_read");
`endif

    // Basic frame with fixed header values.
    run_frame(32'h0123_4567, 4'h5, 16'hA5A5, 0, 0);
    bus_if.sample_raddr = 6'd0;
    tick();
    chk("buf0_header", bus_if.sample_rdata, 32'h5123_4567);
    read_all();

    // Starts at T+10 and T+33 ignored; start at T+34 begins the next frame.
    run_frame($urandom, 4'($urandom), 16'($urandom), 10, N + 1);
    run_frame($urandom, 4'($urandom), 16'($urandom), 0, 0);
    read_all();

    // Reset at T+12 of a frame.
    tick();
    bus_if.sample_start = 1'b1;
    bus_if.timestamp    = $urandom;
    rd_tag              = 16'($urandom);
    for (int k = 1; k <= 12; k++) begin
      tick();
      bus_if.sample_start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy",  {31'd0, bus_if.sample_busy}, 32'd0);
    chk("midrst_raddr", {16'd0, bus_if.reg_raddr}, 32'd0);
    chk("midrst_done",  {31'd0, bus_if.sample_done}, 32'd0);
`ifdef SAMPLE_CAPTURE_DBLBUF_EN
    have_frame = 1'b0;
`endif
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus_if.sample_done === 1'b1) done_seen++;
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
`ifdef SAMPLE_CAPTURE_DBLBUF_EN
    read_check(6'd5, "midrst_read");
`endif

    run_frame($urandom, 4'($urandom), 16'($urandom), 0, 0);
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Responder end of the block-read sampling interface.
- On a `sample_start` pulse from the FPGA module, it takes the register read bus and walks a fixed address list covering board status, motor and encoder registers.
- Captured quadlets go into a 64-entry sample buffer, which the FPGA module reads back through `sample_raddr`/`sample_rdata`.
- Sits on the QLA side, between the board register read mux and the FPGA sampling port.

Parameters:
- NUM_MOTORS, 4, number of motor channels (1..8).
- NUM_ENCODERS, 4, number of encoder channels (1..8).
- NUM_QUADS, 4+2*NUM_MOTORS+5*NUM_ENCODERS, quadlets per sample frame; must be ≤64 (elaboration error otherwise).

Ports:
- sysclk  in  1  system clock, 49.152 MHz
- reset  in  1  synchronous, active-high reset
- sample_start  in  1  one-cycle request to capture a frame
- sample_chan  in  4  requester channel tag, latched at start
- timestamp  in  32  free-running timestamp
- sample_busy  out  1  1 -> this block owns reg_raddr
- reg_raddr  out  16  register read address
- reg_rdata  in  32  register read data, valid 1 cycle after reg_raddr
- sample_raddr  in  6  buffer read address
- sample_rdata  out  32  buffer read data, registered
- sample_done  out  1  one-cycle pulse when a frame is complete

Behaviour:
- Clock and reset: one clock, sysclk; reset is synchronous and active-high.
- Reset values: sample_busy=0, reg_raddr=16'h0000, sample_done=0, sample_rdata=0, state=IDLE, index=0. Buffer RAM is not cleared.
- States:
  - IDLE -> RUN on sample_start.
  - RUN -> FLUSH after address index NUM_QUADS-1 is issued.
  - FLUSH -> DONE.
  - DONE -> IDLE.
- Cycle timing, with sample_start high in IDLE at cycle T:
  - T+1: sample_busy=1. Buffer[0] <= {sample_chan, timestamp[27:0]}, both latched at T. reg_raddr=addr(1).
  - RUN: reg_raddr=addr(i) at T+i for i=1..NUM_QUADS-1. Buffer[i] <= reg_rdata at T+i+1.
  - The final capture, Buffer[NUM_QUADS-1], happens at T+NUM_QUADS (FLUSH). sample_busy stays high through T+NUM_QUADS.
  - T+NUM_QUADS+1 (DONE): sample_busy=0, sample_done=1 for exactly one cycle.
  - Frame latency: NUM_QUADS+1 cycles from start to done.
- Address map: reg_raddr = {8'h00, ch[3:0], off[3:0]}, channels numbered from 1.
  - idx1: 0x0000 (status)
  - idx2: 0x000A (digital I/O)
  - idx3: 0x000B (temperature)
  - next NUM_MOTORS entries: ADC, off=0x0, ch=1..M
  - next NUM_MOTORS entries: motor status, off=0xC, ch=1..M
  - next 5*NUM_ENCODERS entries: grouped by type, off=0x2..0x6 (position, period, quarter, run, velocity). Inner loop is ch=1..E.
- Idle bus: reg_raddr is driven to 0x0000 whenever sample_busy=0.
- Read side:
  - sample_rdata <= Buffer[sample_raddr] one cycle after sample_raddr.
  - sample_raddr ≥ NUM_QUADS returns 32'h0.
- Boundary conditions:
  - sample_start while not IDLE (RUN/FLUSH/DONE): ignored; no queueing, no restart.
  - sample_start in the same cycle as DONE: ignored. A new start is accepted from the next IDLE cycle.
  - reset mid-frame: next cycle is IDLE, sample_busy=0, no sample_done. Partial buffer contents are retained.
  - sample_chan and timestamp changes after T do not affect the frame.
  - Buffer write and read of the same address in the same cycle: read returns the old data.

Optional Feature:
- Macro: SAMPLE_CAPTURE_DBLBUF_EN.
- Defined: two buffer banks.
  - Capture writes the back bank.
  - At DONE, the banks swap in the same cycle as sample_done.
  - sample_rdata always reflects the last complete frame; a reset mid-frame discards the partial bank.
  - Before the first completed frame, reads return 0 (bank valid flag cleared by reset).
- Undefined: single bank.
  - Reads during sample_busy may return a mix of old and new quadlets.
  - Software must wait for sample_done.

Test Plan:
- Basic frame (M=E=4, NUM_QUADS=32):
  - Stimulus: timestamp=32'h0123_4567, sample_chan=4'h5, pulse start at T.
  - Required: busy rises at T+1 and falls at T+33; sample_done at T+33; Buffer[0]=32'h5123_4567.
- Address sequence:
  - Stimulus: bench model returns reg_rdata = {16'hA5A5, previous reg_raddr}.
  - Required: reg_raddr sequence 0x0000, 0x000A, 0x000B, 0x0010..0x0040, 0x001C..0x004C, 0x0012..0x0042, …, 0x0016..0x0046.
  - Required: Buffer[i] = {16'hA5A5, addr(i)} for i=1..31.
- Start while busy:
  - Stimulus: second sample_start at T+10, third at T+33.
  - Required: the T+10 and T+33 pulses have no effect; a start at T+34 begins a new frame (busy at T+35).
- Reset mid-frame:
  - Stimulus: reset at T+12.
  - Required: busy=0 and reg_raddr=0 at T+13; no sample_done; a subsequent start produces a full 32-quad frame.
- Readback bounds:
  - Stimulus: sample_raddr=31, then sample_raddr=40.
  - Required: data of quad 31 after 1 cycle, then 32'h0.
- Double buffer (SAMPLE_CAPTURE_DBLBUF_EN):
  - Stimulus: complete frame A; start frame B; read addr 5 during B.
  - Required: the read returns frame A data; after B's sample_done it returns frame B data.
